// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package im_loader_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } im_state_t;

   // Instruction returned whenever the array is not readable (sll $0,$0,0).
   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // Least-significant bit of each byte lane inside a big-endian word.
   localparam int LANE0_LSB = 24;
   localparam int LANE1_LSB = 16;
   localparam int LANE2_LSB = 8;
   localparam int LANE3_LSB = 0;

   // Maps a lane index to the bit position of its least-significant bit.
   function automatic int laneLsb(input logic [1:0] lane);
      case (lane)
         2'd0:    return LANE0_LSB;
         2'd1:    return LANE1_LSB;
         2'd2:    return LANE2_LSB;
         default: return LANE3_LSB;
      endcase
   endfunction

endpackage

// File: rtl/im_byte_packer.sv
// Packs an accepted byte stream big-endian into 32-bit words.
// Earlier bytes of the current word sit right-justified in a 24-bit shift
// register; the emitted word is {hold, byte} shifted up so the first byte
// lands in lane 0, which also zero-fills the lanes a short word never got.
module im_byte_packer
   import im_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_clear,
   input  logic        i_accept,
   input  logic [7:0]  i_data,
   input  logic        i_last,
   output logic        o_word_valid,
   output logic [31:0] o_word_data,
   output logic        o_word_partial
);

   logic [1:0]  r_lane;
   logic [23:0] r_hold;
   logic [31:0] w_full;
   logic        w_lane3;

   // Decide whether the byte being accepted completes a word, and build it.
   always_comb begin
      w_lane3        = (r_lane == 2'd3);
      w_full         = {r_hold, i_data};
      o_word_valid   = i_accept && (w_lane3 || i_last);
      o_word_partial = i_accept && i_last && !w_lane3;
      o_word_data    = w_full << laneLsb(r_lane);
   end

   // Advance the lane counter and shift in bytes; empty out after each word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lane <= 2'd0;
         r_hold <= 24'h0;
      end else if (i_clear) begin
         r_lane <= 2'd0;
         r_hold <= 24'h0;
      end else if (i_accept) begin
         if (o_word_valid) begin
            r_lane <= 2'd0;
            r_hold <= 24'h0;
         end else begin
            r_lane <= r_lane + 2'd1;
            r_hold <= {r_hold[15:0], i_data};
         end
      end
   end

endmodule

// File: rtl/im_loader.sv
// Byte-stream instruction-memory writer with a CPU-style read port.
// The host loads a program over valid/ready; once the load finishes the
// array is served combinationally, and NOP is returned for anything not
// written by the most recent completed load.
module im_loader
   import im_loader_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int CW          = $clog2(DEPTH_WORDS) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load_start,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   input  logic          in_last,
   output logic          in_ready,
   input  logic [31:0]   instr_addr,
   output logic [31:0]   instr,
   output logic          load_busy,
   output logic          load_done,
   output logic [CW-1:0] word_count,
   output logic          err_overflow,
   output logic          err_partial
);

   localparam int          AW       = $clog2(DEPTH_WORDS);
   localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH_WORDS);
   localparam logic [CW-1:0] ONE_CW   = CW'(1);

   im_state_t r_state;
   im_state_t w_nextState;

   logic          w_accept;
   logic          w_enterLoad;
   logic          w_wordValid;
   logic [31:0]   w_wordData;
   logic          w_wordPartial;
   logic          w_ptrFull;
   logic [AW-1:0] w_rdIdx;
   logic          w_rdHit;
   logic          w_unusedAddrBits;

   // The pointer doubles as the word count; it saturates at DEPTH_WORDS.
   logic [CW-1:0] r_ptr;
   logic          r_errOverflow;
   logic          r_errPartial;
   logic [31:0]   r_mem [DEPTH_WORDS];

   im_byte_packer u_packer (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_clear        (w_enterLoad),
      .i_accept       (w_accept),
      .i_data         (in_data),
      .i_last         (in_last),
      .o_word_valid   (w_wordValid),
      .o_word_data    (w_wordData),
      .o_word_partial (w_wordPartial)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_nextState;
   end

   // Next-state logic plus the handshake and status outputs.
   always_comb begin
      w_nextState = r_state;
      in_ready    = 1'b0;
      load_busy   = 1'b0;
      load_done   = 1'b0;
      w_enterLoad = 1'b0;
      case (r_state)
         IDLE: begin
            if (load_start) begin
               w_nextState = LOAD;
               w_enterLoad = 1'b1;
            end
         end
         LOAD: begin
            in_ready  = 1'b1;
            load_busy = 1'b1;
            if (in_valid && in_last) w_nextState = DONE;
         end
         DONE: begin
            load_done = 1'b1;
            if (load_start) begin
               w_nextState = LOAD;
               w_enterLoad = 1'b1;
            end
         end
         default: w_nextState = IDLE;
      endcase
      w_accept  = in_valid && in_ready;
      w_ptrFull = (r_ptr == DEPTH_CW);
   end

   // Word pointer and sticky error flags, all cleared when a load begins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr         <= '0;
         r_errOverflow <= 1'b0;
         r_errPartial  <= 1'b0;
      end else if (w_enterLoad) begin
         r_ptr         <= '0;
         r_errOverflow <= 1'b0;
         r_errPartial  <= 1'b0;
      end else if (w_accept) begin
         if (w_ptrFull)                 r_errOverflow <= 1'b1;
         if (w_wordValid && !w_ptrFull) r_ptr         <= r_ptr + ONE_CW;
         if (w_wordPartial)             r_errPartial  <= 1'b1;
      end
   end

   // Storage array write port; deliberately unreset so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (w_wordValid && !w_ptrFull) r_mem[r_ptr[AW-1:0]] <= w_wordData;
   end

   // Read port: only words written by the completed load are visible.
   always_comb begin
      w_rdIdx          = instr_addr[AW+1:2];
      w_rdHit          = (r_state == DONE) && ({1'b0, w_rdIdx} < r_ptr);
      instr            = w_rdHit ? r_mem[w_rdIdx] : NOP_WORD;
      w_unusedAddrBits = ^{instr_addr[31:AW+2], instr_addr[1:0]};
   end

   assign word_count   = r_ptr;
   assign err_overflow = r_errOverflow;
   assign err_partial  = r_errPartial;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader with a small (4-word) array so the
// overflow path is reachable. A reference model packs each program into
// expected words and queues them; they are popped and compared on readback.
module tb_im_loader;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic          load_start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_last;
   logic          in_ready;
   logic [31:0]   instr_addr;
   logic [31:0]   instr;
   logic          load_busy;
   logic          load_done;
   logic [CW-1:0] word_count;
   logic          err_overflow;
   logic          err_partial;

   int checks = 0;
   int errors = 0;

   logic [7:0]  txBytes[$];
   logic [31:0] expQ[$];
   int          expCount;
   logic        expPartial;
   logic        expOverflow;

   im_loader #(.DEPTH_WORDS(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_start   (load_start),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .instr_addr   (instr_addr),
      .instr        (instr),
      .load_busy    (load_busy),
      .load_done    (load_done),
      .word_count   (word_count),
      .err_overflow (err_overflow),
      .err_partial  (err_partial)
   );

   // Free-running clock, 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulseLoadStart;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   // Offers one byte and waits (bounded) until the handshake completes.
   task automatic sendByte(input logic [7:0] d, input logic l, input bit gaps);
      bit accepted;
      bit rdy;
      accepted = 1'b0;
      in_data  = d;
      in_last  = l;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            tick();
         end
      end
      in_valid = 1'b1;
      for (int c = 0; c < 50 && !accepted; c++) begin
         rdy = in_ready;
         tick();
         if (rdy) accepted = 1'b1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!accepted) begin
         checks++;
         errors++;
         $display("[TB] FAIL handshake_timeout byte=%02h in_ready=%0b required=1", d, in_ready);
      end
   endtask

   // Model the packed words for txBytes, queue them, then stream the bytes.
   task automatic streamProgram(input bit gaps);
      int n;
      n           = txBytes.size();
      expCount    = 0;
      expPartial  = (n % 4) != 0;
      expOverflow = 1'b0;
      for (int i = 0; i < n; i += 4) begin
         logic [31:0] w;
         w = 32'h0;
         for (int k = 0; k < 4; k++) begin
            if (i + k < n) w[31 - 8*k -: 8] = txBytes[i + k];
         end
         if (expCount < DEPTH) begin
            expQ.push_back(w);
            expCount++;
         end else begin
            expOverflow = 1'b1;
         end
      end
      for (int i = 0; i < n; i++) sendByte(txBytes[i], i == n - 1, gaps);
   endtask

   task automatic test_reset;
      rst_n      = 1'b0;
      load_start = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      in_last    = 1'b0;
      instr_addr = 32'h0;
      #12;
      rst_n = 1'b1;
      tick();
      checks++;
      if (instr !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_instr got=%08h want=00000000", instr);
      end
      checks++;
      if ({in_ready, load_done, load_busy} !== 3'b000) begin
         errors++; $display("[TB] FAIL reset_flags got=%03b want=000", {in_ready, load_done, load_busy});
      end
      checks++;
      if (word_count !== '0 || err_overflow !== 1'b0 || err_partial !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_count got=%0d/%0b/%0b want=0/0/0", word_count, err_overflow, err_partial);
      end
      // Bytes offered in IDLE must be ignored.
      in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0; in_last = 1'b0;
      checks++;
      if (in_ready !== 1'b0 || load_done !== 1'b0 || word_count !== '0) begin
         errors++; $display("[TB] FAIL idle_bytes got=rdy%0b done%0b cnt%0d want=0/0/0", in_ready, load_done, word_count);
      end
   endtask

   task automatic test_basic_load(input bit gaps);
      logic [31:0] exp;
      txBytes = '{8'h00, 8'h22, 8'h40, 8'h20, 8'h01, 8'h09, 8'h50, 8'h22};
      // A handshake coinciding with load_start must not be accepted.
      in_valid = 1'b1; in_data = 8'hFF;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("[TB] FAIL start_ready got=%0b want=0", in_ready);
      end
      pulseLoadStart();
      in_valid = 1'b0;
      checks++;
      if ({in_ready, load_busy, load_done} !== 3'b110 || word_count !== '0) begin
         errors++; $display("[TB] FAIL start_state got=%03b cnt=%0d want=110 cnt=0", {in_ready, load_busy, load_done}, word_count);
      end
      streamProgram(gaps);
      checks++;
      if (load_done !== 1'b1 || load_busy !== 1'b0) begin
         errors++; $display("[TB] FAIL done_after_last gaps=%0b got=done%0b busy%0b want=1/0", gaps, load_done, load_busy);
      end
      checks++;
      if (word_count !== CW'(expCount) || err_partial !== expPartial || err_overflow !== expOverflow) begin
         errors++; $display("[TB] FAIL basic_status got=%0d/%0b/%0b want=%0d/%0b/%0b", word_count, err_partial, err_overflow, expCount, expPartial, expOverflow);
      end
      for (int i = 0; expQ.size() > 0; i++) begin
         exp = expQ.pop_front();
         instr_addr = 32'(i*4 + (i % 4));
         #1;
         checks++;
         if (instr !== exp) begin
            errors++; $display("[TB] FAIL basic_word%0d got=%08h want=%08h", i, instr, exp);
         end
      end
      instr_addr = 32'd8;
      #1;
      checks++;
      if (instr !== 32'h0) begin
         errors++; $display("[TB] FAIL basic_beyond got=%08h want=00000000", instr);
      end
   endtask

   task automatic test_partial;
      logic [31:0] exp;
      txBytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11};
      pulseLoadStart();
      streamProgram(1'b0);
      checks++;
      if (word_count !== CW'(2) || err_partial !== 1'b1 || err_overflow !== 1'b0 || load_done !== 1'b1) begin
         errors++; $display("[TB] FAIL partial_status got=%0d/%0b/%0b/%0b want=2/1/0/1", word_count, err_partial, err_overflow, load_done);
      end
      for (int i = 0; expQ.size() > 0; i++) begin
         exp = expQ.pop_front();
         instr_addr = 32'(i*4);
         #1;
         checks++;
         if (instr !== exp) begin
            errors++; $display("[TB] FAIL partial_word%0d got=%08h want=%08h", i, instr, exp);
         end
      end
      instr_addr = 32'd4;
      #1;
      checks++;
      if (instr !== 32'h1100_0000) begin
         errors++; $display("[TB] FAIL partial_zero_fill got=%08h want=11000000", instr);
      end
   endtask

   task automatic test_overflow;
      logic [31:0] exp;
      txBytes.delete();
      for (int i = 0; i < 20; i++) txBytes.push_back(8'(i*37 + 3));
      pulseLoadStart();
      streamProgram(1'b1);
      checks++;
      if (word_count !== CW'(DEPTH) || err_overflow !== 1'b1 || err_partial !== 1'b0 || load_done !== 1'b1) begin
         errors++; $display("[TB] FAIL overflow_status got=%0d/%0b/%0b/%0b want=%0d/1/0/1", word_count, err_overflow, err_partial, load_done, DEPTH);
      end
      for (int i = 0; expQ.size() > 0; i++) begin
         exp = expQ.pop_front();
         instr_addr = 32'(i*4 + 3);
         #1;
         checks++;
         if (instr !== exp) begin
            errors++; $display("[TB] FAIL overflow_word%0d got=%08h want=%08h", i, instr, exp);
         end
      end
      // Restarting clears count and both flags and hides the array.
      pulseLoadStart();
      instr_addr = 32'd0;
      #1;
      checks++;
      if (word_count !== '0 || err_overflow !== 1'b0 || err_partial !== 1'b0 || load_busy !== 1'b1) begin
         errors++; $display("[TB] FAIL restart_clear got=%0d/%0b/%0b/%0b want=0/0/0/1", word_count, err_overflow, err_partial, load_busy);
      end
      checks++;
      if (instr !== 32'h0) begin
         errors++; $display("[TB] FAIL restart_hidden got=%08h want=00000000", instr);
      end
   endtask

   task automatic test_reset_midload;
      logic [31:0] exp;
      if (!load_busy) pulseLoadStart();
      for (int i = 0; i < 6; i++) sendByte(8'hC0 + 8'(i), 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, load_busy, load_done} !== 3'b000 || word_count !== '0 || err_overflow !== 1'b0 || err_partial !== 1'b0 || instr !== 32'h0) begin
         errors++; $display("[TB] FAIL async_reset got=%03b cnt=%0d ovf=%0b par=%0b instr=%08h want=000 0 0 0 00000000",
                            {in_ready, load_busy, load_done}, word_count, err_overflow, err_partial, instr);
      end
      tick();
      rst_n = 1'b1;
      tick();
      txBytes = '{8'h12, 8'h34, 8'h56, 8'h78};
      pulseLoadStart();
      streamProgram(1'b0);
      exp = expQ.pop_front();
      instr_addr = 32'd0;
      #1;
      checks++;
      if (instr !== exp || word_count !== CW'(1)) begin
         errors++; $display("[TB] FAIL reload_word0 got=%08h cnt=%0d want=%08h cnt=1", instr, word_count, exp);
      end
      instr_addr = 32'd4;
      #1;
      checks++;
      if (instr !== 32'h0) begin
         errors++; $display("[TB] FAIL reload_stale got=%08h want=00000000", instr);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_basic_load(1'b0);
      test_basic_load(1'b1);
      test_partial();
      test_overflow();
      test_reset_midload();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
